// File: rtl/vx_launch_pkg.sv
// Shared types and DCR address map for the host-side kernel launcher.
// Addresses alias the VX_DCR_BASE_* startup/MPM registers.
package vx_launch_pkg;

   localparam int VX_DCR_ADDR_WIDTH = 12;

   localparam logic [11:0] DCR_STARTUP_ADDR0 = 12'h001;
   localparam logic [11:0] DCR_STARTUP_ADDR1 = 12'h002;
   localparam logic [11:0] DCR_STARTUP_ARG0  = 12'h003;
   localparam logic [11:0] DCR_STARTUP_ARG1  = 12'h004;
   localparam logic [11:0] DCR_MPM_CLASS     = 12'h005;

   localparam logic [2:0] LAST_IDX = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_WAIT_BUSY,
      S_RUN,
      S_DONE,
      S_ERR
   } state_e;

   typedef struct packed {
      logic [63:0] addr;
      logic [63:0] arg;
      logic [31:0] mpm;
   } launch_cmd_t;

   function automatic logic [11:0] dcr_addr(input logic [2:0] idx);
      logic [11:0] a;
      a = DCR_MPM_CLASS;
      unique case (idx)
         3'd0:    a = DCR_STARTUP_ADDR0;
         3'd1:    a = DCR_STARTUP_ADDR1;
         3'd2:    a = DCR_STARTUP_ARG0;
         3'd3:    a = DCR_STARTUP_ARG1;
         default: a = DCR_MPM_CLASS;
      endcase
      return a;
   endfunction

endpackage

// File: rtl/vx_dcr_launcher_timer.sv
// Saturating up-counter with clear, load-one and terminal-count flag.
// Shared by the start timeout and the run-cycle measurement.
module vx_launch_timer #(
   parameter int          W  = 32,
   parameter logic [W-1:0] TC = '1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_clr,
   input  logic         i_set,
   input  logic         i_inc,
   output logic [W-1:0] o_cnt,
   output logic         o_tc
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_set) begin
         r_cnt <= W'(1);
      end else if (i_inc && !(&r_cnt)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_cnt = r_cnt;
   assign o_tc  = (r_cnt == TC);

endmodule

// File: rtl/vx_dcr_launcher.sv
// Host-side launcher: takes one command, streams the startup DCR
// writes, then tracks the GPU busy window for completion or timeout.
module vx_dcr_launcher
   import vx_launch_pkg::*;
#(
   parameter int DCR_ADDR_W     = VX_DCR_ADDR_WIDTH,
   parameter int DCR_DATA_W     = 32,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CYC_W          = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [63:0]           cmd_startup_addr,
   input  logic [63:0]           cmd_startup_arg,
   input  logic [31:0]           cmd_mpm_class,
   output logic                  write_valid,
   output logic [DCR_ADDR_W-1:0] write_addr,
   output logic [DCR_DATA_W-1:0] write_data,
   input  logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [CYC_W-1:0]      run_cycles,
   output logic                  active
);

   localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [TO_W-1:0] TO_TC = TO_W'(TIMEOUT_CYCLES - 1);

   state_e      r_state, w_next;
   launch_cmd_t r_cmd;
   logic [2:0]  r_idx;

   logic                  w_accept;
   logic                  w_wr_valid;
   logic [DCR_ADDR_W-1:0] w_wr_addr;
   logic [31:0]           w_wr_data;
   logic                  w_to_clr, w_to_inc, w_to_tc;
   logic                  w_rc_clr, w_rc_set, w_rc_inc, w_rc_sat;
   logic [TO_W-1:0]       w_to_cnt;

   always_ff @(posedge clk) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:      if (cmd_valid) w_next = S_WRITE;
         S_WRITE:     if (r_idx == LAST_IDX + 3'd1) w_next = S_WAIT_BUSY;
         S_WAIT_BUSY: begin
            if (busy)         w_next = S_RUN;
            else if (w_to_tc) w_next = S_ERR;
         end
         S_RUN:       if (!busy) w_next = S_DONE;
         S_DONE:      w_next = S_IDLE;
         S_ERR:       w_next = S_IDLE;
         default:     w_next = S_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready  = (r_state == S_IDLE);
      active     = (r_state != S_IDLE);
      done       = (r_state == S_DONE);
      error      = (r_state == S_ERR);
      w_accept   = cmd_valid && cmd_ready;
      w_wr_valid = (r_state == S_WRITE) && (r_idx <= LAST_IDX);
      w_wr_addr  = DCR_ADDR_W'(dcr_addr(r_idx));
      w_wr_data  = r_cmd.mpm;
      unique case (r_idx)
         3'd0:    w_wr_data = r_cmd.addr[31:0];
         3'd1:    w_wr_data = r_cmd.addr[63:32];
         3'd2:    w_wr_data = r_cmd.arg[31:0];
         3'd3:    w_wr_data = r_cmd.arg[63:32];
         default: w_wr_data = r_cmd.mpm;
      endcase
      w_to_clr = (r_state == S_WRITE);
      w_to_inc = (r_state == S_WAIT_BUSY) && !busy;
      w_rc_clr = w_accept;
      w_rc_set = (r_state == S_WAIT_BUSY) && busy;
      w_rc_inc = (r_state == S_RUN) && busy && !w_rc_sat;
   end

   // Address/data only move on a strobe so they hold between writes.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_idx       <= '0;
         r_cmd       <= '0;
         write_valid <= 1'b0;
         write_addr  <= '0;
         write_data  <= '0;
      end else begin
         write_valid <= w_wr_valid;
         if (w_wr_valid) begin
            write_addr <= w_wr_addr;
            write_data <= DCR_DATA_W'(w_wr_data);
         end
         if (w_accept) begin
            r_idx <= '0;
            r_cmd <= '{addr: cmd_startup_addr,
                       arg:  cmd_startup_arg,
                       mpm:  cmd_mpm_class};
         end else if (r_state == S_WRITE) begin
            r_idx <= r_idx + 3'd1;
         end
      end
   end

   vx_launch_timer #(
      .W  (TO_W),
      .TC (TO_TC)
   ) u_timeout (
      .clk   (clk),
      .reset (reset),
      .i_clr (w_to_clr),
      .i_set (1'b0),
      .i_inc (w_to_inc),
      .o_cnt (w_to_cnt),
      .o_tc  (w_to_tc)
   );

   vx_launch_timer #(
      .W  (CYC_W),
      .TC ('1)
   ) u_runcyc (
      .clk   (clk),
      .reset (reset),
      .i_clr (w_rc_clr),
      .i_set (w_rc_set),
      .i_inc (w_rc_inc),
      .o_cnt (run_cycles),
      .o_tc  (w_rc_sat)
   );

   logic w_unused;
   assign w_unused = ^w_to_cnt;

endmodule

// File: doc/vx_dcr_launcher.md
Name: vx_dcr_launcher

Overview:
- Upstream host-side stage that drives the DCR write port (write_valid/write_addr/write_data) and observes busy of VX_top.
- Accepts one kernel-launch command over a valid/ready handshake, then emits the fixed DCR write sequence: startup address, startup argument, MPM class.
- Tracks the GPU busy lifetime, reports completion or a start timeout, and measures kernel run time in cycles.

Parameters:
- DCR_ADDR_W, VX_DCR_ADDR_WIDTH: DCR address width.
- DCR_DATA_W, 32: DCR data width. Only 32 is supported.
- TIMEOUT_CYCLES, 1024: maximum cycles to wait for busy to rise after the last write.
- CYC_W, 32: width of the run-cycle counter.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-low reset.
- cmd_valid  input  1  launch request.
- cmd_ready  output  1  launcher idle and able to accept a command.
- cmd_startup_addr  input  64  kernel PC.
- cmd_startup_arg  input  64  kernel argument pointer.
- cmd_mpm_class  input  32  MPM class value.
- write_valid  output  1  DCR write strobe.
- write_addr  output  DCR_ADDR_W  DCR address.
- write_data  output  DCR_DATA_W  DCR data.
- busy  input  1  GPU busy from VX_top.
- done  output  1  one-cycle pulse: kernel finished.
- error  output  1  one-cycle pulse: busy never rose.
- run_cycles  output  CYC_W  cycles busy was high during the last launch.
- active  output  1  launcher not in IDLE.

Behaviour:
- Reset: sampled on posedge clk while reset==0.
  - All outputs go to 0 and the state goes to IDLE, except cmd_ready, which is 1 once in IDLE.
  - Reset mid-sequence aborts immediately. No further writes are emitted.
- States: IDLE, WRITE, WAIT_BUSY, RUN, DONE, ERR.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, capture all three command fields into registers, clear run_cycles, and go to WRITE with idx=0.
- WRITE:
  - One write per cycle. DCR writes have no back-pressure.
  - Registered outputs: write_valid=1 in cycles T+1..T+5, where T is the accept edge.
  - Sequence by idx:
    - 0: STARTUP_ADDR0 = addr[31:0]
    - 1: STARTUP_ADDR1 = addr[63:32]
    - 2: STARTUP_ARG0 = arg[31:0]
    - 3: STARTUP_ARG1 = arg[63:32]
    - 4: MPM_CLASS = mpm
  - After idx 4, go to WAIT_BUSY and clear the timeout counter.
  - write_addr and write_data hold their last values when write_valid=0; only write_valid is meaningful.
- WAIT_BUSY:
  - busy is ignored in all other states before this one.
  - If busy==1, go to RUN and set run_cycles=1.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT_CYCLES-1 with busy still 0, go to ERR.
- RUN:
  - While busy==1, increment run_cycles, saturating at all-ones (no wrap).
  - On busy==0, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- ERR: error=1 for exactly one cycle, then IDLE.
- run_cycles holds its value until the next command is accepted.
- active=1 in every state except IDLE.
- cmd_ready=0 outside IDLE. A cmd_valid held during a launch is accepted on the first IDLE cycle.
- A busy glitch during RUN (1→0→1) ends the launch at the first 0. No re-arm.
- A command arriving the same cycle done pulses is not accepted until the following IDLE cycle.

Decomposition:
- Shared package vx_launch_pkg:
  - State enum.
  - DCR address constants: STARTUP_ADDR0=0x001, STARTUP_ADDR1=0x002, STARTUP_ARG0=0x003, STARTUP_ARG1=0x004, MPM_CLASS=0x005. These alias the VX_DCR_BASE_* defines.
  - The launch_cmd_t struct {addr, arg, mpm}.
- Optional sub-module vx_launch_timer: combined saturating counter with a terminal-count flag, reused for the timeout and run_cycles.

Test Plan:
- Basic launch:
  - Stimulus: hold reset low 3 cycles, then issue cmd addr=0x0000_0001_8000_0000, arg=0x0000_0000_9000_0040, mpm=0.
  - Required: exactly five writes on consecutive cycles, (0x001, 0x8000_0000), (0x002, 0x1), (0x003, 0x9000_0040), (0x004, 0x0), (0x005, 0x0). cmd_ready=0 throughout.
- Run timing:
  - Stimulus: busy rises 3 cycles after the last write and stays high 20 cycles.
  - Required: done pulses once, one cycle after busy falls. run_cycles=20. active falls with the return to IDLE.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=16, busy held at 0.
  - Required: error pulses 17 cycles after the last write. done never asserts. Back to IDLE with cmd_ready=1.
- Back-to-back:
  - Stimulus: second cmd_valid held high during RUN.
  - Required: accepted on the first IDLE cycle after done. The second write sequence uses the second command's data.
- Reset mid-write:
  - Stimulus: assert reset on the edge after the 2nd write.
  - Required: write_valid=0 on the next cycle, no further writes, run_cycles=0, cmd_ready=1 after reset deasserts.
- Saturation:
  - Stimulus: CYC_W=4, busy high 40 cycles.
  - Required: run_cycles=15, done pulses normally.
